r2mdc_stage_sequencer: RTL and testbench

Central controller for the R2MDC FFT pipeline.
- Accepts the incoming stream of input pairs and tracks their valid qualifier through every butterfly stage.
- Generates per-stage pair counters; these drive the pre-delay commutator FF write/read indices.
- Generates commutator switch selects, stage enables and frame-level status.
- Sits between the input interface and the chain of butterfly + pre-delay-commutator stages; replaces the free-running per-stage counters.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/valid_delay_line.sv | 37 +++
 rtl/r2mdc_stage_sequencer.sv | 99 +++++++++
 tb/tb_r2mdc_stage_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared sizing constants and delay helpers for the R2MDC FFT pipeline control.
// Stage delays halve at each stage; the last stage has no commutator delay.
package fft_pkg;

  localparam int NUM_INPUTS_PER_PATH = 32;
  localparam int CNT_W               = $clog2(NUM_INPUTS_PER_PATH);
  localparam int NUM_STAGES          = CNT_W + 1;
  localparam int BF_LATENCY          = 1;

  function automatic int stage_delay(input int s);
    if (s >= NUM_STAGES - 1) return 0;
    return NUM_INPUTS_PER_PATH >> (s + 1);
  endfunction

  // Input-to-output latency: every stage adds its butterfly register plus its delay.
  function automatic int total_latency();
    int acc;
    acc = 0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      acc += BF_LATENCY + stage_delay(s);
    end
    return acc;
  endfunction

  localparam int BUSY_W = $clog2(total_latency() + 1);

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit valid shift register with asynchronous active-low clear.
// DEPTH of zero degenerates to a wire so a stage with no delay costs nothing.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK & RST_N;
      assign dout = din;
    end else begin : g_shift
      logic shreg [DEPTH];

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < DEPTH; i++) begin
            shreg[i] <= 1'b0;
          end
        end else begin
          shreg[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            shreg[i] <= shreg[i-1];
          end
        end
      end

      assign dout = shreg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/r2mdc_stage_sequencer.sv
// Central controller for the R2MDC FFT pipeline: valid tracking through every
// stage, per-stage pair counters, commutator selects and frame status.
module r2mdc_stage_sequencer
  import fft_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          in_valid,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic [NUM_STAGES*CNT_W-1:0]   cntr_IFFT_input_pairs,
  output logic [NUM_STAGES-2:0]         cm_sel,
  output logic                          out_valid,
  output logic                          frame_start,
  output logic                          frame_done,
  output logic                          busy
);

  logic [CNT_W-1:0]  stage_cnt [NUM_STAGES];
  logic [CNT_W-1:0]  out_cnt;
  logic [BUSY_W-1:0] inflight;

  assign stage_valid[0] = in_valid;

  generate
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          stage_cnt[s] <= '0;
        end else if (stage_valid[s]) begin
          stage_cnt[s] <= stage_cnt[s] + 1'b1;
        end
      end

      assign cntr_IFFT_input_pairs[s*CNT_W +: CNT_W] = stage_cnt[s];

      if (s < NUM_STAGES - 1) begin : g_link
        localparam int SEL_BIT = CNT_W - 1 - s;
        logic cm_hold;

        valid_delay_line #(
          .DEPTH (BF_LATENCY + stage_delay(s))
        ) u_valid_dly (
          .CLK   (CLK),
          .RST_N (RST_N),
          .din   (stage_valid[s]),
          .dout  (stage_valid[s+1])
        );

        // The counter has already advanced past the last pair, so the select
        // keeps its own copy of the bit used by that pair for idle cycles.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) begin
            cm_hold <= 1'b0;
          end else if (stage_valid[s]) begin
            cm_hold <= stage_cnt[s][SEL_BIT];
          end
        end

        assign cm_sel[s] = stage_valid[s] ? stage_cnt[s][SEL_BIT] : cm_hold;
      end
    end
  endgenerate

  valid_delay_line #(
    .DEPTH (BF_LATENCY)
  ) u_out_dly (
    .CLK   (CLK),
    .RST_N (RST_N),
    .din   (stage_valid[NUM_STAGES-1]),
    .dout  (out_valid)
  );

  // Pair index as seen at the output, one butterfly after the last stage counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_cnt <= '0;
    end else if (out_valid) begin
      out_cnt <= out_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight <= '0;
    end else begin
      case ({in_valid, out_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign frame_start = in_valid && (stage_cnt[0] == '0);
  assign frame_done  = out_valid && (out_cnt == CNT_W'(NUM_INPUTS_PER_PATH - 1));
  assign busy        = (inflight != '0);

endmodule

// File: tb/tb_r2mdc_stage_sequencer.sv
// Directed bench for the R2MDC stage sequencer: reset, single frame,
// back-to-back frames, gapped input and reset in the middle of a frame.
module tb_r2mdc_stage_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic [5:0]  stage_valid;
  logic [29:0] cntr_IFFT_input_pairs;
  logic [4:0]  cm_sel;
  logic        out_valid;
  logic        frame_start;
  logic        frame_done;
  logic        busy;

  int vectors;
  int miscompares;

  logic        in_pat   [128];
  logic        rst_pat  [128];
  logic [5:0]  obs_sv   [128];
  logic [29:0] obs_cnt  [128];
  logic [4:0]  obs_cm   [128];
  logic        obs_ov   [128];
  logic        obs_fs   [128];
  logic        obs_fd   [128];
  logic        obs_busy [128];

  r2mdc_stage_sequencer dut (
    .CLK                   (CLK),
    .RST_N                 (RST_N),
    .in_valid              (in_valid),
    .stage_valid           (stage_valid),
    .cntr_IFFT_input_pairs (cntr_IFFT_input_pairs),
    .cm_sel                (cm_sel),
    .out_valid             (out_valid),
    .frame_start           (frame_start),
    .frame_done            (frame_done),
    .busy                  (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic clear_patterns();
    for (int k = 0; k < 128; k++) begin
      in_pat[k]  = 1'b0;
      rst_pat[k] = 1'b0;
    end
  endtask

  // Cycle k is the period after the k-th clock edge following reset release.
  task automatic run_cycles(input int n);
    RST_N    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      RST_N    = ~rst_pat[k];
      in_valid = in_pat[k] & ~rst_pat[k];
      @(negedge CLK);
      obs_sv[k]   = stage_valid;
      obs_cnt[k]  = cntr_IFFT_input_pairs;
      obs_cm[k]   = cm_sel;
      obs_ov[k]   = out_valid;
      obs_fs[k]   = frame_start;
      obs_fd[k]   = frame_done;
      obs_busy[k] = busy;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST_N    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({stage_valid, cntr_IFFT_input_pairs, cm_sel, out_valid, frame_start, frame_done, busy} !== 45'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got sv=%b cnt=%h cm=%b ov=%b fs=%b fd=%b busy=%b, expected all zero",
               stage_valid, cntr_IFFT_input_pairs, cm_sel, out_valid, frame_start, frame_done, busy);
    end
    @(posedge CLK);
    #1;
    RST_N    = 1'b1;
    in_valid = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_busy_before: got %b expected 1", busy);
    end
    vectors++;
    if (cntr_IFFT_input_pairs[4:0] !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL reset_cnt0_before: got %0d expected 5", cntr_IFFT_input_pairs[4:0]);
    end
    #2;
    RST_N    = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({stage_valid, cntr_IFFT_input_pairs, cm_sel, out_valid, frame_start, frame_done, busy} !== 45'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got sv=%b cnt=%h cm=%b ov=%b fs=%b fd=%b busy=%b, expected all zero",
               stage_valid, cntr_IFFT_input_pairs, cm_sel, out_valid, frame_start, frame_done, busy);
    end
  endtask

  task automatic test_single_frame();
    int first_sv1;
    clear_patterns();
    for (int k = 0; k < 32; k++) in_pat[k] = 1'b1;
    run_cycles(110);
    for (int k = 0; k < 110; k++) begin
      logic e_ov, e_fd, e_fs;
      e_ov = (k >= 37) && (k <= 68);
      e_fd = (k == 68);
      e_fs = (k == 0);
      vectors++;
      if (obs_ov[k] !== e_ov) begin
        miscompares++;
        $display("[TB] FAIL single_out_valid cycle %0d: got %b expected %b", k, obs_ov[k], e_ov);
      end
      vectors++;
      if (obs_fd[k] !== e_fd) begin
        miscompares++;
        $display("[TB] FAIL single_frame_done cycle %0d: got %b expected %b", k, obs_fd[k], e_fd);
      end
      vectors++;
      if (obs_fs[k] !== e_fs) begin
        miscompares++;
        $display("[TB] FAIL single_frame_start cycle %0d: got %b expected %b", k, obs_fs[k], e_fs);
      end
    end
    first_sv1 = -1;
    for (int k = 0; k < 110; k++) begin
      if (first_sv1 < 0 && obs_sv[k][1] === 1'b1) first_sv1 = k;
    end
    vectors++;
    if (first_sv1 != 17) begin
      miscompares++;
      $display("[TB] FAIL single_sv1_first: got cycle %0d expected 17", first_sv1);
    end
    vectors++;
    if (obs_busy[1] !== 1'b1 || obs_busy[68] !== 1'b1 || obs_busy[69] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_busy: got c1=%b c68=%b c69=%b expected 1 1 0",
               obs_busy[1], obs_busy[68], obs_busy[69]);
    end
    for (int j = 0; j < 32; j++) begin
      logic e_cm0, e_cm4;
      logic [4:0] e_idx;
      e_cm0 = (j >= 16);
      e_cm4 = j[0];
      e_idx = 5'(j);
      vectors++;
      if (obs_cm[j][0] !== e_cm0) begin
        miscompares++;
        $display("[TB] FAIL single_cm_sel0 pair %0d: got %b expected %b", j, obs_cm[j][0], e_cm0);
      end
      vectors++;
      if (obs_sv[34+j][4] !== 1'b1 || obs_cm[34+j][4] !== e_cm4) begin
        miscompares++;
        $display("[TB] FAIL single_cm_sel4 pair %0d: got sv4=%b cm4=%b expected 1 %b",
                 j, obs_sv[34+j][4], obs_cm[34+j][4], e_cm4);
      end
      vectors++;
      if (obs_cnt[26+j][14:10] !== e_idx) begin
        miscompares++;
        $display("[TB] FAIL single_cnt2 pair %0d: got %0d expected %0d", j, obs_cnt[26+j][14:10], e_idx);
      end
      vectors++;
      if (obs_cnt[j][4:0] !== e_idx) begin
        miscompares++;
        $display("[TB] FAIL single_cnt0 cycle %0d: got %0d expected %0d", j, obs_cnt[j][4:0], e_idx);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_patterns();
    for (int k = 0; k < 64; k++) in_pat[k] = 1'b1;
    run_cycles(110);
    for (int k = 0; k < 110; k++) begin
      logic e_ov, e_fd, e_fs;
      e_ov = (k >= 37) && (k <= 100);
      e_fd = (k == 68) || (k == 100);
      e_fs = (k == 0) || (k == 32);
      vectors++;
      if (obs_ov[k] !== e_ov) begin
        miscompares++;
        $display("[TB] FAIL b2b_out_valid cycle %0d: got %b expected %b", k, obs_ov[k], e_ov);
      end
      vectors++;
      if (obs_fd[k] !== e_fd) begin
        miscompares++;
        $display("[TB] FAIL b2b_frame_done cycle %0d: got %b expected %b", k, obs_fd[k], e_fd);
      end
      vectors++;
      if (obs_fs[k] !== e_fs) begin
        miscompares++;
        $display("[TB] FAIL b2b_frame_start cycle %0d: got %b expected %b", k, obs_fs[k], e_fs);
      end
    end
    for (int j = 0; j < 64; j++) begin
      logic [4:0] e_idx;
      e_idx = 5'(j % 32);
      vectors++;
      if (obs_cnt[26+j][14:10] !== e_idx) begin
        miscompares++;
        $display("[TB] FAIL b2b_cnt2 pair %0d: got %0d expected %0d", j, obs_cnt[26+j][14:10], e_idx);
      end
      vectors++;
      if (obs_cnt[36+j][29:25] !== e_idx) begin
        miscompares++;
        $display("[TB] FAIL b2b_cnt5 pair %0d: got %0d expected %0d", j, obs_cnt[36+j][29:25], e_idx);
      end
    end
  endtask

  task automatic test_gapped();
    clear_patterns();
    for (int k = 1; k < 64; k += 2) in_pat[k] = 1'b1;
    run_cycles(110);
    for (int k = 0; k < 110; k++) begin
      logic e_ov, e_fd, e_fs;
      e_ov = (k >= 37) ? in_pat[k-37] : 1'b0;
      e_fd = (k == 100);
      e_fs = (k == 1);
      vectors++;
      if (obs_ov[k] !== e_ov) begin
        miscompares++;
        $display("[TB] FAIL gap_out_valid cycle %0d: got %b expected %b", k, obs_ov[k], e_ov);
      end
      vectors++;
      if (obs_fd[k] !== e_fd) begin
        miscompares++;
        $display("[TB] FAIL gap_frame_done cycle %0d: got %b expected %b", k, obs_fd[k], e_fd);
      end
      vectors++;
      if (obs_fs[k] !== e_fs) begin
        miscompares++;
        $display("[TB] FAIL gap_frame_start cycle %0d: got %b expected %b", k, obs_fs[k], e_fs);
      end
    end
    for (int k = 1; k <= 70; k++) begin
      int v;
      logic e_cm0;
      logic [4:0] e_idx;
      v     = (k > 63) ? 63 : ((k % 2 == 1) ? k : k - 1);
      e_cm0 = ((v / 2) >= 16);
      e_idx = (k <= 64) ? 5'((k / 2) % 32) : 5'd0;
      vectors++;
      if (obs_cm[k][0] !== e_cm0) begin
        miscompares++;
        $display("[TB] FAIL gap_cm_sel0 cycle %0d: got %b expected %b", k, obs_cm[k][0], e_cm0);
      end
      vectors++;
      if (obs_cnt[k][4:0] !== e_idx) begin
        miscompares++;
        $display("[TB] FAIL gap_cnt0 cycle %0d: got %0d expected %0d", k, obs_cnt[k][4:0], e_idx);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_patterns();
    for (int k = 0; k < 20; k++) in_pat[k] = 1'b1;
    rst_pat[20] = 1'b1;
    rst_pat[21] = 1'b1;
    for (int k = 25; k < 57; k++) in_pat[k] = 1'b1;
    run_cycles(100);
    vectors++;
    if (obs_cnt[19][4:0] !== 5'd19) begin
      miscompares++;
      $display("[TB] FAIL midrst_cnt0_pre: got %0d expected 19", obs_cnt[19][4:0]);
    end
    vectors++;
    if ({obs_sv[20], obs_cnt[20], obs_cm[20], obs_ov[20], obs_fs[20], obs_fd[20], obs_busy[20]} !== 45'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_outputs_zero: got sv=%b cnt=%h cm=%b ov=%b fs=%b fd=%b busy=%b, expected all zero",
               obs_sv[20], obs_cnt[20], obs_cm[20], obs_ov[20], obs_fs[20], obs_fd[20], obs_busy[20]);
    end
    for (int k = 0; k < 100; k++) begin
      logic e_ov;
      e_ov = (k >= 62) && (k <= 93);
      vectors++;
      if (obs_ov[k] !== e_ov) begin
        miscompares++;
        $display("[TB] FAIL midrst_out_valid cycle %0d: got %b expected %b", k, obs_ov[k], e_ov);
      end
    end
    vectors++;
    if (obs_fs[25] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_frame_start: got %b expected 1", obs_fs[25]);
    end
    vectors++;
    if (obs_cnt[25][4:0] !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_cnt0_new: got %0d expected 0", obs_cnt[25][4:0]);
    end
    vectors++;
    if (obs_fd[93] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_frame_done: got %b expected 1", obs_fd[93]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST_N       = 1'b0;
    in_valid    = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
